// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-ported memory.
// It has a data-first priority with a fetch starvation guard and a lost-ack timeout watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic [DATA_W-1:0]   f_rdata,
  output logic                f_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned RunW  = $clog2(MAX_DATA_RUN + 1);
  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam int unsigned BeW   = DATA_W / 8;
  localparam logic [DATA_W-1:0] NopInsn = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StGrantF, StGrantD, StResp} state_e;

  state_e              state_q;
  logic [RunW-1:0]     run_q;
  logic [WaitW-1:0]    wait_q;
  logic [DATA_W-1:0]   f_rdata_q, d_rdata_q;
  logic                f_ack_q, d_ack_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BeW-1:0]      mem_be_q;
  logic                timeout_err_q;

  logic starved, wait_expired;

  // Fetch has waited through the maximum run of back-to-back data grants.
  assign starved      = f_req && (run_q == RunW'(MAX_DATA_RUN));
  assign wait_expired = (wait_q == WaitW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      run_q         <= '0;
      wait_q        <= '0;
      f_rdata_q     <= '0;
      d_rdata_q     <= '0;
      f_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_req && !starved) begin
            state_q     <= StGrantD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_be;
            wait_q      <= '0;
            run_q       <= f_req ? run_q + RunW'(1) : '0;
          end else if (f_req) begin
            state_q    <= StGrantF;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= f_addr;
            mem_be_q   <= '1;
            wait_q     <= '0;
            run_q      <= '0;
          end
        end
        StGrantF, StGrantD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= StResp;
            if (state_q == StGrantF) begin
              f_ack_q   <= 1'b1;
              f_rdata_q <= mem_rdata;
            end else begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= mem_rdata;
            end
          end else if (wait_expired) begin
            // Abort: answer with a safe value so the pipeline can proceed.
            mem_req_q     <= 1'b0;
            state_q       <= StResp;
            timeout_err_q <= 1'b1;
            if (state_q == StGrantF) begin
              f_ack_q   <= 1'b1;
              f_rdata_q <= NopInsn;
            end else begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= '0;
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign f_rdata     = f_rdata_q;
  assign f_ack       = f_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter.
// The memory model derives data, wait states and dropped acks from the address.
module tb_mem_port_arbiter;
  localparam int unsigned MaxRun  = 4;
  localparam int unsigned Timeout = 15;
  localparam int NumF = 40;
  localparam int NumD = 60;

  typedef struct packed {
    logic [31:0] data;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        f_ack, d_ack, mem_req, mem_we, mem_ack, busy, timeout_err;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  exp_t f_q[$];
  exp_t d_q[$];
  logic chk_en    = 1'b0;
  logic force_ack = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MaxRun), .TIMEOUT(Timeout)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction
  function automatic int mem_waits(input logic [31:0] a);
    return int'(a[5:4]);
  endfunction
  function automatic logic mem_drop(input logic [31:0] a);
    return a[9:6] == 4'hF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model; garbage acks while idle must be ignored by the arbiter.
  int wcnt = 0;
  always @(negedge clk) begin
    mem_rdata = $urandom;
    if (force_ack) begin
      mem_ack = 1'b1;
      wcnt    = 0;
    end else if (mem_req) begin
      mem_ack = 1'b0;
      if (!mem_drop(mem_addr) && wcnt == mem_waits(mem_addr)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_fn(mem_addr);
      end
      wcnt++;
    end else begin
      wcnt    = 0;
      mem_ack = ($urandom_range(0, 3) == 0);
    end
  end

  // Response scoreboard.
  logic exp_terr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) exp_terr = 1'b0;
    if (f_ack && d_ack) chk("both_acks", 1, 0);
    if (f_ack) begin
      if (f_q.size() == 0) chk("f_ack_unexpected", 1, 0);
      else begin
        e = f_q.pop_front();
        if (e.to) exp_terr = 1'b1;
        chk("f_rdata", f_rdata, e.data);
        chk("f_timeout_err", timeout_err, exp_terr);
      end
    end
    if (d_ack) begin
      if (d_q.size() == 0) chk("d_ack_unexpected", 1, 0);
      else begin
        e = d_q.pop_front();
        if (e.to) exp_terr = 1'b1;
        chk("d_rdata", d_rdata, e.data);
        chk("d_timeout_err", timeout_err, exp_terr);
      end
    end
  end

  // Grant and port-timing monitor with a transaction-level arbitration model.
  logic        pend, was_req, idle_next, cur_d, p_d, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  int          run, len, exp_len, n_starve;
  always @(negedge clk) begin
    if (!chk_en) begin
      pend = 0; was_req = 0; idle_next = 0; run = 0;
    end else begin
      if (pend) begin
        chk("grant_req", mem_req, 1);
        chk("grant_addr", mem_addr, p_addr);
        chk("grant_we", mem_we, p_we);
        chk("grant_be", mem_be, p_be);
        if (p_d) chk("grant_wdata", mem_wdata, p_wdata);
        pend    = 0;
        cur_d   = p_d;
        exp_len = mem_drop(p_addr) ? Timeout : mem_waits(p_addr) + 1;
        len     = 0;
      end
      if (mem_req) begin
        len++;
        was_req = 1;
      end else if (was_req) begin
        chk("req_len", len, exp_len);
        chk("f_ack_owner", f_ack, !cur_d);
        chk("d_ack_owner", d_ack, cur_d);
        was_req   = 0;
        idle_next = 1;
      end else if (idle_next) begin
        chk("busy_after_ack", busy, 0);
        idle_next = 0;
      end
      if (!busy && (f_req || d_req)) begin
        if (d_req && !(f_req && run == MaxRun)) begin
          p_d = 1; p_addr = d_addr; p_we = d_we; p_be = d_be; p_wdata = d_wdata;
          run = f_req ? run + 1 : 0;
        end else begin
          if (d_req) n_starve++;
          p_d = 0; p_addr = f_addr; p_we = 0; p_be = 4'hF; run = 0;
        end
        pend = 1;
      end
    end
  end

  task automatic wait_f_ack();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!f_ack && cyc < 200);
    if (!f_ack) chk("f_ack_wait_bound", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_d_ack();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!d_ack && cyc < 200);
    if (!d_ack) chk("d_ack_wait_bound", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_drv();
    logic [31:0] a;
    for (int n = 0; n < NumF; n++) begin
      f_req = 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a     = $urandom;
      a[31] = 1'b0;
      if (n == 2) a[9:6] = 4'hF;
      f_addr = a;
      f_req  = 1;
      f_q.push_back('{data: mem_drop(a) ? 32'h13 : mem_fn(a), to: mem_drop(a)});
      wait_f_ack();
    end
    f_req = 0;
  endtask

  task automatic data_drv();
    logic [31:0] a, last;
    logic        we;
    last = 32'h0;
    for (int n = 0; n < NumD; n++) begin
      d_req = 0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      a       = $urandom;
      a[31]   = 1'b1;
      we      = $urandom_range(0, 1) == 1;
      d_addr  = a;
      d_we    = we;
      d_wdata = $urandom;
      d_be    = 4'($urandom);
      d_req   = 1;
      if (!we) last = mem_drop(a) ? 32'h0 : mem_fn(a);
      d_q.push_back('{data: last, to: mem_drop(a)});
      wait_d_ack();
    end
    d_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 0; f_req = 0; d_req = 0; d_we = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    n_starve = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_terr", timeout_err, 0);
    reset  = 1;
    chk_en = 1;
    @(posedge clk);
    #1;
    fork
      fetch_drv();
      data_drv();
    join
    repeat (3) @(posedge clk);
    chk("f_queue_drained", f_q.size(), 0);
    chk("d_queue_drained", d_q.size(), 0);
    chk("starvation_seen", n_starve > 0, 1);

    // Reset while a data read is waiting on memory.
    chk_en = 0;
    #1;
    d_we   = 0;
    d_addr = 32'h8000_0030;
    d_req  = 1;
    begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!mem_req && cyc < 10);
      chk("rst_phase_grant", mem_req, 1);
    end
    reset     = 0;
    d_req     = 0;
    force_ack = 1;
    @(negedge clk);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_d_ack", d_ack, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    chk("mid_rst_f_rdata", f_rdata, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_mem_be", mem_be, 0);
    reset = 1;
    @(negedge clk);
    force_ack = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stale_ack_busy", busy, 0);
      chk("stale_ack_d_ack", d_ack, 0);
      chk("stale_ack_mem_req", mem_req, 0);
    end

    // Zero-wait fetch after reset recovers cleanly.
    chk_en = 1;
    @(posedge clk);
    #1;
    f_addr = 32'h40;
    f_req  = 1;
    f_q.push_back('{data: mem_fn(32'h40), to: 1'b0});
    wait_f_ack();
    f_req = 0;
    repeat (2) @(posedge clk);
    chk("final_f_queue", f_q.size(), 0);
    chk("final_terr", timeout_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one single-ported unified memory between the pipeline's instruction-fetch stage and its memory stage. It serializes the two streams onto the memory port and returns read data to the requester that issued each transaction. Fetch and data requests use a req/ack handshake, so the hazard logic can stall on an outstanding request. It also includes a starvation guard and a timeout watchdog, so a lost memory acknowledge cannot hang the pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, maximum consecutive data grants while fetch is waiting (≥1)
- TIMEOUT, 15, number of cycles `mem_req` may stay high without `mem_ack` before abort (≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; `reset==0` at a rising edge resets the block
- f_req  in  1  fetch request; held with `f_addr` stable until `f_ack`
- f_addr  in  ADDR_W  fetch address
- f_rdata  out  DATA_W  fetch read data, valid when `f_ack`=1, then held
- f_ack  out  1  one-cycle response pulse to fetch
- d_req  in  1  data request; held with its fields stable until `d_ack`
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  data read result, valid when `d_ack`=1, then held
- d_ack  out  1  one-cycle response pulse to data
- mem_req  out  1  memory request, registered
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request
- mem_rdata  in  DATA_W  memory read data, sampled when `mem_ack`=1
- mem_ack  in  1  memory completion; valid only while `mem_req`=1
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

## Operation
States and transitions:
- **IDLE**
  - d_req and not starved -> GRANT_D.
  - Else f_req -> GRANT_F.
  - Else stay in IDLE.
  - On a grant, latch the request fields into the `mem_*` registers and set `mem_req`=1 (visible the next cycle). Fetch grants force `mem_we`=0 and `mem_be`=all ones.
- **GRANT_F / GRANT_D**
  - Hold `mem_req` and the `mem_*` fields.
  - On `mem_ack`: capture `mem_rdata`, clear `mem_req`, go to RESP.
  - On timeout: clear `mem_req`, go to RESP with the abort value.
- **RESP**
  - Pulse the ack of the owning requester.
  - Drive the captured data on its rdata.
  - Go to IDLE.
  - No arbitration occurs in RESP.
- **Starvation:** run counter `run`, width clog2(MAX_DATA_RUN+1).
  - A data grant with `f_req`=1 increments `run`.
  - A data grant with `f_req`=0 clears `run`.
  - A fetch grant clears `run`.
  - Starved means `f_req` & (`run`==MAX_DATA_RUN). In that case fetch wins even if `d_req`=1.
- **Timeout:** wait counter cleared on entry to GRANT_x and incremented each GRANT cycle without `mem_ack`. Abort occurs when the count reaches TIMEOUT-1 with no ack.
  - Fetch abort data: `f_rdata`=32'h0000_0013 (NOP).
  - Data read abort: `d_rdata`=0.
  - `timeout_err` is set.
- `d_rdata` updates only on read responses; a write response pulses `d_ack` and leaves `d_rdata` unchanged.
- `mem_ack` in IDLE or RESP is ignored.
- A requester must drop req or present a new request in the cycle after its ack; any req seen in IDLE is treated as new.
- Reset: all outputs 0 (`f_rdata`, `d_rdata`, `mem_*` included); state=IDLE; `run`=0; wait counter=0; `timeout_err`=0.
  - Reset mid-transaction drops `mem_req` at that edge.
  - Reset mid-transaction produces no ack for the aborted transaction.

## Timing
- Cycle 0: IDLE sees req.
- Cycle 1: `mem_req`=1.
- Zero-wait memory (ack in cycle 1): cycle 2 RESP/ack, cycle 3 IDLE. This is the minimum 3-cycle request-to-next-arbitration turnaround.
- Each memory wait cycle adds exactly 1 cycle.
- Timeout path: `mem_req` is high for exactly TIMEOUT cycles, and the ack comes on the following cycle.
- `f_ack` and `d_ack` are never high together and are never high outside RESP.
- At most one memory transaction is outstanding at any time.

## Test plan
- **Zero-wait fetch:** f_req, f_addr=0x40, `mem_ack` in the same cycle as `mem_req`, `mem_rdata`=0x00500093.
  - Expect `mem_req` in cycle 1, `f_ack` in cycle 2 with `f_rdata`=0x00500093, `busy` low in cycle 3.
- **Simultaneous requests:** `f_req`=`d_req`=1 in IDLE, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xA5A5A5A5.
  - Expect the data write granted first: `mem_we`=1, `mem_addr`=0x100.
  - Then `d_ack` with `d_rdata` unchanged.
  - Then fetch granted.
- **Starvation:** continuous `d_req` and `f_req`, MAX_DATA_RUN=4.
  - Expect grant order D,D,D,D,F,D,D,D,D,F.
- **Wait states:** data read, `mem_ack` after 3 wait cycles, `mem_rdata`=0x12345678.
  - Expect `mem_req` high for 4 cycles and `d_ack` with `d_rdata`=0x12345678 the cycle after.
- **Timeout:** fetch with `mem_ack` never asserted, TIMEOUT=15.
  - Expect `mem_req` high for 15 cycles, then `f_ack` with `f_rdata`=0x00000013 and `timeout_err`=1, which stays 1 through later successful transactions.
- **Reset mid-transaction:** reset=0 for 1 cycle while in GRANT_D.
  - Expect `mem_req`=0, `busy`=0, `timeout_err`=0 and all outputs 0 after that edge.
  - Expect no `d_ack`.
  - A stale `mem_ack` in the next cycle is ignored.
